calc_result_formatter: RTL

Sequential binary-to-BCD formatter directly downstream of the 4-bit calculator ALU. It accepts one ALU result word per valid/ready handshake and interprets it according to the operation code: BCD sum with carry, two's-complement difference, 8-bit product, or packed quotient/remainder. It converts the magnitude to three BCD digits with a shift-add-3 (double-dabble) engine. It presents the digits plus sign and error flags to the display driver through a second valid/ready handshake.

---
 rtl/calc_pkg.sv | 45 ++++
 rtl/bcd_add3.sv | 10 +
 rtl/calc_result_formatter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator result formatter: op codes, FSM states,
// the blank display code and leading-zero blanking helpers.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } calc_op_e;

  typedef enum logic [1:0] {
    FMT_IDLE = 2'd0,
    FMT_CONV = 2'd1,
    FMT_DONE = 2'd2
  } fmt_state_e;

  localparam logic [3:0] BCD_BLANK  = 4'hF;
  localparam int         BCD_DIGITS = 3;
  localparam int         MAG_W      = 8;

  // The ones digit is always shown; only zero digits above the first
  // non-zero one are replaced by the blank code.
  function automatic logic [11:0] blank_digits(input logic [11:0] d);
    logic [11:0] r;
    r = d;
    if (d[11:8] == 4'd0) begin
      r[11:8] = BCD_BLANK;
      if (d[7:4] == 4'd0) begin
        r[7:4] = BCD_BLANK;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] blank_rem(input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (d[7:4] == 4'd0) begin
      r[7:4] = BCD_BLANK;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: digits of 5 or more get +3 before the shift
// so that the doubled value carries correctly into the next BCD digit.
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/calc_result_formatter.sv
// Sequential binary-to-BCD formatter for ALU results (add/sub/mul/div).
// Optional build macro CALC_FMT_BLANK_EN: blank leading zero digits with 4'hF.
//
// Handshakes: a word transfers on in_valid & in_ready at a rising edge, and the
// formatted outputs transfer on out_valid & out_ready; each valid, once raised,
// stays high with stable data until its ready is seen.
module calc_result_formatter
  import calc_pkg::*;
#(
  parameter int CONV_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [7:0]  result,
  input  logic        status,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] digits,
  output logic [7:0]  rem_digits,
  output logic        neg,
  output logic        err,
  output fmt_state_e  dbg_state
);

  localparam int SHIFT_W = 4 * BCD_DIGITS + CONV_BITS;

  fmt_state_e             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [CONV_BITS-1:0]   bin_q, bin_d;
  logic [11:0]            bcd_q, bcd_d;
  logic                   neg_pend_q, neg_pend_d;
  logic                   err_pend_q, err_pend_d;
  logic [7:0]             rem_pend_q, rem_pend_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [11:0]            digits_q, digits_d;
  logic [7:0]             rem_digits_q, rem_digits_d;
  logic                   neg_q, neg_d;
  logic                   err_q, err_d;

  logic [MAG_W-1:0]       ld_mag;
  logic                   ld_neg;
  logic                   ld_err;
  logic [7:0]             ld_rem;
  logic [11:0]            bcd_adj;
  logic [SHIFT_W-1:0]     shift_w;
  logic [11:0]            bcd_shift;
  logic [CONV_BITS-1:0]   bin_shift;
  logic [11:0]            digits_fmt;
  logic [7:0]             rem_fmt;

  // Interpret the ALU word at accept time; nothing from the inputs is used later.
  always_comb begin
    ld_mag = '0;
    ld_neg = 1'b0;
    ld_err = 1'b0;
    ld_rem = '0;
    case (calc_op_e'(op))
      OP_ADD: begin
        ld_mag = status ? (8'd10 + {4'd0, result[3:0]}) : {4'd0, result[3:0]};
      end
      OP_SUB: begin
        if (result[7]) begin
          ld_mag = (~result + 8'd1) & 8'h1F;
          ld_neg = 1'b1;
        end else begin
          ld_mag = {3'd0, result[4:0]};
        end
      end
      OP_MUL: begin
        ld_mag = result;
      end
      OP_DIV: begin
        if (status) begin
          ld_err = 1'b1;
        end else begin
          ld_mag = {4'd0, result[3:0]};
          ld_rem = (result[7:4] >= 4'd10) ? {4'd1, result[7:4] - 4'd10}
                                          : {4'd0, result[7:4]};
        end
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_i (bcd_q[4*g +: 4]),
      .nib_o (bcd_adj[4*g +: 4])
    );
  end

  assign shift_w   = {bcd_adj, bin_q} << 1;
  assign bcd_shift = shift_w[SHIFT_W-1 -: 12];
  assign bin_shift = shift_w[CONV_BITS-1:0];

`ifdef CALC_FMT_BLANK_EN
  assign digits_fmt = blank_digits(bcd_shift);
  assign rem_fmt    = blank_rem(rem_pend_q);
`else
  assign digits_fmt = bcd_shift;
  assign rem_fmt    = rem_pend_q;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    neg_pend_d   = neg_pend_q;
    err_pend_d   = err_pend_q;
    rem_pend_d   = rem_pend_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    digits_d     = digits_q;
    rem_digits_d = rem_digits_q;
    neg_d        = neg_q;
    err_d        = err_q;
    case (state_q)
      FMT_IDLE: begin
        if (in_valid) begin
          state_d    = FMT_CONV;
          cnt_d      = 4'd0;
          bin_d      = CONV_BITS'(ld_mag);
          bcd_d      = '0;
          neg_pend_d = ld_neg;
          err_pend_d = ld_err;
          rem_pend_d = ld_rem;
          in_ready_d = 1'b0;
        end
      end
      FMT_CONV: begin
        bcd_d = bcd_shift;
        bin_d = bin_shift;
        cnt_d = cnt_q + 4'd1;
        // The final shift result goes straight to the outputs on this edge.
        if (cnt_q == 4'(CONV_BITS - 1)) begin
          state_d      = FMT_DONE;
          cnt_d        = 4'd0;
          out_valid_d  = 1'b1;
          digits_d     = digits_fmt;
          rem_digits_d = rem_fmt;
          neg_d        = neg_pend_q;
          err_d        = err_pend_q;
        end
      end
      FMT_DONE: begin
        if (out_ready) begin
          state_d     = FMT_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = FMT_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FMT_IDLE;
      cnt_q        <= 4'd0;
      bin_q        <= '0;
      bcd_q        <= '0;
      neg_pend_q   <= 1'b0;
      err_pend_q   <= 1'b0;
      rem_pend_q   <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      digits_q     <= '0;
      rem_digits_q <= '0;
      neg_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      neg_pend_q   <= neg_pend_d;
      err_pend_q   <= err_pend_d;
      rem_pend_q   <= rem_pend_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      digits_q     <= digits_d;
      rem_digits_q <= rem_digits_d;
      neg_q        <= neg_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign digits     = digits_q;
  assign rem_digits = rem_digits_q;
  assign neg        = neg_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule
